mips_inst_issuer: RTL and testbench

- Drives the instruction port of the MIPS pipeline core; it is the transmit end of that core's in_valid / instruction / output_reg interface.
- Accepts abstract operation requests (op, register indices, shamt, imm, readback selects) through a valid/ready handshake.
- Encodes each request into a 32-bit MIPS word plus a 20-bit readback selector and buffers it in a small FIFO.
- Issues at most one instruction per cycle, throttled by an outstanding-instruction credit counter. The counter is returned by the core's out_valid.

---
 rtl/mips_inst_issuer.sv | 165 ++++++++++++++++
 tb/tb_mips_inst_issuer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_inst_issuer.sv
// rtl/mips_inst_issuer.sv - encodes operation requests into MIPS words and issues them under a credit limit
module mips_inst_issuer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [2:0]       req_rs,
  input  logic [2:0]       req_rt,
  input  logic [2:0]       req_rd,
  input  logic [4:0]       req_shamt,
  input  logic [15:0]      req_imm,
  input  logic [31:0]      req_raw,
  input  logic [11:0]      req_rdsel,
  output logic             in_valid,
  output logic [31:0]      instruction,
  output logic [19:0]      output_reg,
  input  logic             out_valid,
  input  logic             instruction_fail,
  output logic             busy,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  MAX_C   = 4'(MAX_OUTSTANDING);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;

  // Core register file addresses; 6 and 7 map to an illegal address on purpose
  // so that the core flags a failure (fault injection path).
  function automatic logic [4:0] reg_map(input logic [2:0] idx);
    case (idx)
      3'd0:    reg_map = 5'b10001;
      3'd1:    reg_map = 5'b10010;
      3'd2:    reg_map = 5'b01000;
      3'd3:    reg_map = 5'b10111;
      3'd4:    reg_map = 5'b11111;
      3'd5:    reg_map = 5'b10000;
      default: reg_map = 5'b00000;
    endcase
  endfunction

  logic [31:0]     enc_instr;
  logic [19:0]     enc_oreg;
  logic [5:0]      funct;
  logic [4:0]      shamt_eff;

  logic [51:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [3:0]      outstanding;
  logic            full;
  logic            empty;
  logic            push;
  logic            issue;
  logic            credit_ret;
  logic [51:0]     head;

  // Combinational encoder from the request fields to {instruction, output_reg}.
  always_comb begin
    funct     = 6'b100000;
    shamt_eff = 5'd0;
    enc_instr = 32'd0;
    case (req_op)
      OP_ADD: funct = 6'b100000;
      OP_AND: funct = 6'b100100;
      OP_OR:  funct = 6'b100101;
      OP_NOR: funct = 6'b100111;
      OP_SLL: begin funct = 6'b000000; shamt_eff = req_shamt; end
      OP_SRL: begin funct = 6'b000010; shamt_eff = req_shamt; end
      default: funct = 6'b100000;
    endcase
    if (req_op == OP_ADDI)
      enc_instr = {6'b001000, reg_map(req_rs), reg_map(req_rt), req_imm};
    else if (req_op == 3'd7)
      enc_instr = req_raw;
    else
      enc_instr = {6'b000000, reg_map(req_rs), reg_map(req_rt), reg_map(req_rd), shamt_eff, funct};
    enc_oreg = {reg_map(req_rdsel[11:9]), reg_map(req_rdsel[8:6]),
                reg_map(req_rdsel[5:3]), reg_map(req_rdsel[2:0])};
  end

  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign req_ready  = !full && !rst;
  assign push       = req_valid && req_ready;
  assign issue      = !empty && (outstanding < MAX_C);
  // A return with nothing outstanding is a stale result from before reset.
  assign credit_ret = out_valid && (outstanding != 4'd0);
  assign head       = mem[rd_ptr];
  assign busy       = !empty || (outstanding != 4'd0);

  // FIFO storage; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_instr, enc_oreg};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outstanding-instruction credit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 4'd0;
    end else begin
      case ({issue, credit_ret})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Registered issue port; idle cycles drive zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid    <= 1'b0;
      instruction <= 32'd0;
      output_reg  <= 20'd0;
    end else begin
      in_valid    <= issue;
      instruction <= issue ? head[51:20] : 32'd0;
      output_reg  <= issue ? head[19:0]  : 20'd0;
    end
  end

  // Statistics counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_cnt <= '0;
      fail_cnt   <= '0;
    end else begin
      if (issue)                         issued_cnt <= issued_cnt + CNT_W'(1);
      if (out_valid && instruction_fail) fail_cnt   <= fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_inst_issuer.sv
// tb/tb_mips_inst_issuer.sv - directed self-checking bench for mips_inst_issuer
module tb_mips_inst_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_op, req_rs, req_rt, req_rd;
  logic [4:0]  req_shamt;
  logic [15:0] req_imm;
  logic [31:0] req_raw;
  logic [11:0] req_rdsel;

  logic        req_valid_a, req_ready_a, in_valid_a, out_valid_a, fail_a, busy_a;
  logic [31:0] instruction_a;
  logic [19:0] output_reg_a;
  logic [15:0] issued_cnt_a, fail_cnt_a;

  logic        req_valid_b, req_ready_b, in_valid_b, out_valid_b, fail_b, busy_b;
  logic [31:0] instruction_b;
  logic [19:0] output_reg_b;
  logic [15:0] issued_cnt_b, fail_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int iss_a   = 0;
  int iss_b   = 0;
  int exp_issued = 0;

  always #5 clk = ~clk;

  mips_inst_issuer #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_raw(req_raw), .req_rdsel(req_rdsel),
    .in_valid(in_valid_a), .instruction(instruction_a), .output_reg(output_reg_a),
    .out_valid(out_valid_a), .instruction_fail(fail_a), .busy(busy_a),
    .issued_cnt(issued_cnt_a), .fail_cnt(fail_cnt_a)
  );

  mips_inst_issuer #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_shamt(req_shamt), .req_imm(req_imm), .req_raw(req_raw), .req_rdsel(req_rdsel),
    .in_valid(in_valid_b), .instruction(instruction_b), .output_reg(output_reg_b),
    .out_valid(out_valid_b), .instruction_fail(fail_b), .busy(busy_b),
    .issued_cnt(issued_cnt_b), .fail_cnt(fail_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    iss_a += int'(in_valid_a);
    iss_b += int'(in_valid_b);
  endtask

  task automatic set_req(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [31:0] raw, input logic [11:0] rdsel);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_shamt = sh; req_imm = imm; req_raw = raw; req_rdsel = rdsel;
  endtask

  task automatic send_a(input string tag, input logic [31:0] ei, input logic [19:0] eo,
                        input logic f);
    req_valid_a = 1'b1;
    step();
    req_valid_a = 1'b0;
    check({tag, "_lat0"}, in_valid_a, 1'b0);
    step();
    exp_issued++;
    check({tag, "_valid"}, in_valid_a, 1'b1);
    check({tag, "_instr"}, instruction_a, ei);
    check({tag, "_oreg"}, output_reg_a, eo);
    check({tag, "_cnt"}, issued_cnt_a, exp_issued);
    check({tag, "_busy"}, busy_a, 1'b1);
    step();
    check({tag, "_idle"}, {in_valid_a, instruction_a, output_reg_a}, 53'd0);
    out_valid_a = 1'b1;
    fail_a = f;
    step();
    out_valid_a = 1'b0;
    fail_a = 1'b0;
    check({tag, "_done"}, busy_a, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid_a = 0; out_valid_a = 0; fail_a = 0;
    req_valid_b = 0; out_valid_b = 0; fail_b = 0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_ready", req_ready_a, 1'b0);
    check("rst_valid", {in_valid_a, instruction_a, output_reg_a}, 53'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_cnt", {issued_cnt_a, fail_cnt_a}, 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", req_ready_a, 1'b1);

    // Single-request encodings; ADD carries a nonzero shamt that must be dropped.
    set_req(3'd0, 3'd1, 3'd2, 3'd0, 5'd5, 16'h0, 32'h0, 12'h000);
    send_a("add", 32'h02488820, 20'h8C631, 1'b0);
    set_req(3'd4, 3'd0, 3'd3, 3'd2, 5'd3, 16'h0, 32'h0, 12'h000);
    send_a("sll", 32'h023740C0, 20'h8C631, 1'b0);
    set_req(3'd3, 3'd3, 3'd4, 3'd5, 5'd0, 16'h0, 32'h0, 12'h000);
    send_a("nor", 32'h02FF8027, 20'h8C631, 1'b0);
    set_req(3'd6, 3'd0, 3'd1, 3'd0, 5'd0, 16'h0005, 32'h0, 12'h000);
    send_a("addi", 32'h22320005, 20'h8C631, 1'b0);
    set_req(3'd7, 3'd0, 3'd0, 3'd0, 5'd0, 16'h0, 32'hDEADBEEF, 12'hB1A);
    send_a("raw", 32'hDEADBEEF, 20'h87EE8, 1'b0);

    // Illegal source register index, with the core reporting failure.
    set_req(3'd0, 3'd7, 3'd0, 3'd0, 5'd0, 16'h0, 32'h0, 12'h000);
    send_a("bad_rs", 32'h00118820, 20'h8C631, 1'b1);
    check("fail_cnt", fail_cnt_a, 16'd1);

    // Burst of 8 with no returns: 4 issue, 4 fill the FIFO.
    iss_a = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(3'd0, 3'(i % 6), 3'd1, 3'd2, 5'd0, 16'h0, 32'h0, 12'h000);
      req_valid_a = 1'b1;
      for (int k = 0; k < 20 && !req_ready_a; k++) step();
      check("burst_ready_wait", req_ready_a, 1'b1);
      step();
    end
    req_valid_a = 1'b0;
    check("burst_issues", iss_a, 4);
    check("burst_full", req_ready_a, 1'b0);
    step(); step(); step();
    check("burst_hold", iss_a, 4);
    check("burst_hold_cnt", issued_cnt_a, exp_issued + 4);

    // One return while full: FIFO still full this cycle, then issue+return together.
    out_valid_a = 1'b1;
    step();
    check("full_pop_ready", req_ready_a, 1'b0);
    check("full_pop_iss", iss_a, 4);
    step();
    out_valid_a = 1'b0;
    check("pop_issue", iss_a, 5);
    check("pop_ready", req_ready_a, 1'b1);
    step();
    check("same_cycle_keep", iss_a, 6);
    step(); step();
    check("credit_exhausted", iss_a, 6);
    out_valid_a = 1'b1;
    step(); step();
    out_valid_a = 1'b0;
    step(); step(); step();
    check("drain_issues", iss_a, 8);
    exp_issued += 8;
    check("drain_cnt", issued_cnt_a, exp_issued);
    out_valid_a = 1'b1;
    step(); step(); step();
    check("drain_busy3", busy_a, 1'b1);
    step();
    out_valid_a = 1'b0;
    check("drain_busy4", busy_a, 1'b0);

    // Serialized issuer: each issue waits for the previous return.
    set_req(3'd1, 3'd0, 3'd1, 3'd2, 5'd0, 16'h0, 32'h0, 12'h000);
    req_valid_b = 1'b1;
    step(); step(); step();
    req_valid_b = 1'b0;
    check("ser_first", iss_b, 1);
    step(); step(); step();
    check("ser_hold", iss_b, 1);
    check("ser_busy", busy_b, 1'b1);
    out_valid_b = 1'b1;
    step();
    out_valid_b = 1'b0;
    check("ser_ret_gap", in_valid_b, 1'b0);
    step();
    check("ser_second", iss_b, 2);
    out_valid_b = 1'b1;
    step();
    out_valid_b = 1'b0;
    check("ser_gap2", iss_b, 2);
    step();
    check("ser_third", iss_b, 3);
    check("ser_instr", instruction_b, 32'h02324024);
    out_valid_b = 1'b1;
    step();
    out_valid_b = 1'b0;
    check("ser_done", {busy_b, issued_cnt_b}, {1'b0, 16'd3});

    // Reset mid-burst with entries queued and instructions outstanding.
    req_valid_a = 1'b1;
    for (int i = 0; i < 7; i++) step();
    req_valid_a = 1'b0;
    check("pre_rst_busy", busy_a, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", in_valid_a, 1'b0);
    check("mid_rst_ready", req_ready_a, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check("post_rst_busy", busy_a, 1'b0);
    check("post_rst_cnt", {issued_cnt_a, fail_cnt_a}, 32'd0);
    check("post_rst_out", {in_valid_a, instruction_a, output_reg_a}, 53'd0);
    out_valid_a = 1'b1;
    step();
    out_valid_a = 1'b0;
    check("stray_ret_busy", busy_a, 1'b0);
    exp_issued = 0;
    set_req(3'd2, 3'd5, 3'd4, 3'd3, 5'd0, 16'h0, 32'h0, 12'h000);
    send_a("post_rst_or", 32'h021FB825, 20'h8C631, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
